// File: rtl/serbus_pkg.sv
// Shared state, phase and command encodings for the serial bus bridge.
package serbus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CMD,
        S_DATA,
        S_DONE
    } state_e;

    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_ADDR = 2'b01;
    localparam logic [1:0] PH_CMD  = 2'b10;
    localparam logic [1:0] PH_DATA = 2'b11;

    localparam int CMD_WE    = 0;
    localparam int CMD_VALID = 1;

endpackage

// File: rtl/serial_bus_bridge_if.sv
// CPU-side request/acknowledge bundle of the serial bus bridge.
interface serial_bus_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_err
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_err
    );
endinterface

// File: rtl/serbus_beat_ctr.sv
// Beat counter that wraps to zero after 'last' and flags the terminal beat.
module serbus_beat_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic         term
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign term = (cnt_q == last);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = term ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/serial_bus_bridge.sv
// Serialises one CPU transaction into LSB-first pin beats: address, command, data.
module serial_bus_bridge
    import serbus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PIN_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_bus_bridge_if.slave cpu,
    output logic               bus_busy,
    output logic [PIN_W-1:0]   pin_addr,
    output logic               pin_strobe,
    output logic [1:0]         pin_phase,
    output logic [PIN_W-1:0]   pin_io_out,
    input  logic [PIN_W-1:0]   pin_io_in,
    output logic [PIN_W-1:0]   pin_io_oe,
    input  logic               ext_ready
);
    localparam int NA = ADDR_W / PIN_W;
    localparam int ND = DATA_W / PIN_W;
    localparam int NB = (NA > ND) ? NA : ND;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BW-1:0] A_LAST = BW'(NA - 1);
    localparam logic [BW-1:0] D_LAST = BW'(ND - 1);
    localparam logic [SW-1:0] S_LAST = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    if ((ADDR_W % PIN_W) != 0 || (DATA_W % PIN_W) != 0 || PIN_W < 2) begin : g_bad_cfg
        $error("serial_bus_bridge: widths must be multiples of PIN_W and PIN_W >= 2");
    end

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  shadow_q, shadow_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [PIN_W-1:0]   pa_q, pa_d;
    logic               stb_q, stb_d;
    logic [1:0]         ph_q, ph_d;
    logic [PIN_W-1:0]   pio_q, pio_d;
    logic [PIN_W-1:0]   oe_q, oe_d;

    logic               b_clr, b_inc, b_term;
    logic               s_clr, s_inc, s_term;
    logic               to_done;
    logic [BW-1:0]      b_last;

    assign b_last = (state_q == S_ADDR) ? A_LAST : D_LAST;

    serbus_beat_ctr #(.W(BW)) u_beat (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (b_clr),
        .inc   (b_inc),
        .last  (b_last),
        .term  (b_term)
    );

    serbus_beat_ctr #(.W(SW)) u_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (s_clr),
        .inc   (s_inc),
        .last  (S_LAST),
        .term  (s_term)
    );

    // Capture registers shift right so the next beat always sits in the low PIN_W bits.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        pa_d     = pa_q;
        stb_d    = stb_q;
        ph_d     = ph_q;
        pio_d    = pio_q;
        oe_d     = oe_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        b_clr    = 1'b0;
        b_inc    = 1'b0;
        s_clr    = 1'b1;
        s_inc    = 1'b0;
        to_done  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                b_clr = 1'b1;
                if (cpu.cpu_req) begin
                    state_d = S_ADDR;
                    we_d    = cpu.cpu_we;
                    addr_d  = cpu.cpu_addr >> PIN_W;
                    wdata_d = cpu.cpu_wdata;
                    busy_d  = 1'b1;
                    stb_d   = 1'b1;
                    ph_d    = PH_ADDR;
                    pa_d    = cpu.cpu_addr[PIN_W-1:0];
                end
            end
            S_ADDR: begin
                b_inc = 1'b1;
                if (b_term) begin
                    state_d         = S_CMD;
                    ph_d            = PH_CMD;
                    pa_d            = '0;
                    pa_d[CMD_VALID] = 1'b1;
                    pa_d[CMD_WE]    = we_q;
                end else begin
                    pa_d   = addr_q[PIN_W-1:0];
                    addr_d = addr_q >> PIN_W;
                end
            end
            S_CMD: begin
                state_d = S_DATA;
                ph_d    = PH_DATA;
                pa_d    = '0;
                oe_d    = {PIN_W{we_q}};
                pio_d   = we_q ? wdata_q[PIN_W-1:0] : '0;
                wdata_d = wdata_q >> PIN_W;
            end
            S_DATA: begin
                if (ext_ready) begin
                    b_inc = 1'b1;
                    if (!we_q) begin
                        shadow_d = {pin_io_in, shadow_q[DATA_W-1:PIN_W]};
                    end
                    if (b_term) begin
                        to_done = 1'b1;
                        if (!we_q) begin
                            rdata_d = shadow_d;
                        end
                    end else if (we_q) begin
                        pio_d   = wdata_q[PIN_W-1:0];
                        wdata_d = wdata_q >> PIN_W;
                    end
                end else begin
                    s_clr = 1'b0;
                    s_inc = 1'b1;
                    if (TIMEOUT != 0 && s_term) begin
                        to_done = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (to_done) begin
            state_d = S_DONE;
            ack_d   = 1'b1;
            ph_d    = PH_IDLE;
            stb_d   = 1'b0;
            pa_d    = '0;
            pio_d   = '0;
            oe_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            pa_q     <= '0;
            stb_q    <= 1'b0;
            ph_q     <= PH_IDLE;
            pio_q    <= '0;
            oe_q     <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            pa_q     <= pa_d;
            stb_q    <= stb_d;
            ph_q     <= ph_d;
            pio_q    <= pio_d;
            oe_q     <= oe_d;
        end
    end

    assign cpu.cpu_rdata = rdata_q;
    assign cpu.cpu_ack   = ack_q;
    assign cpu.cpu_err   = err_q;
    assign bus_busy      = busy_q;
    assign pin_addr      = pa_q;
    assign pin_strobe    = stb_q;
    assign pin_phase     = ph_q;
    assign pin_io_out    = pio_q;
    assign pin_io_oe     = oe_q;
endmodule

// File: tb/tb_serial_bus_bridge.sv
// Randomised bench for serial_bus_bridge: per-cycle trace model plus directed literal cases.
module tb_serial_bus_bridge;
    localparam int TO = 15;

    typedef struct {
        logic [1:0]  ph;
        logic        stb;
        logic        busy;
        logic        ack;
        logic        err;
        logic        oe_on;
        logic        chk_pa;
        logic [7:0]  pa;
        logic        chk_pio;
        logic [7:0]  pio;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_cyc = -1;
    logic        ack_err;
    logic [31:0] ack_rdata;
    logic [31:0] prev_rd = '0;
    logic [7:0]  obs_pa [64];
    exp_t ex;
    bit   chk_en = 1'b0;

    serial_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    logic       bus_busy, pin_strobe, ext_ready;
    logic [1:0] pin_phase;
    logic [7:0] pin_addr, pin_io_out, pin_io_in, pin_io_oe;

    serial_bus_bridge #(.ADDR_W(32), .DATA_W(32), .PIN_W(8), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu        (bus),
        .bus_busy   (bus_busy),
        .pin_addr   (pin_addr),
        .pin_strobe (pin_strobe),
        .pin_phase  (pin_phase),
        .pin_io_out (pin_io_out),
        .pin_io_in  (pin_io_in),
        .pin_io_oe  (pin_io_oe),
        .ext_ready  (ext_ready)
    );

    serial_bus_bridge_if #(.ADDR_W(16), .DATA_W(8)) b4 ();
    logic       s_busy, s_strobe, s_ready;
    logic [1:0] s_phase;
    logic [3:0] s_addr, s_io_out, s_io_in, s_oe;

    serial_bus_bridge #(.ADDR_W(16), .DATA_W(8), .PIN_W(4), .TIMEOUT(TO)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu        (b4),
        .bus_busy   (s_busy),
        .pin_addr   (s_addr),
        .pin_strobe (s_strobe),
        .pin_phase  (s_phase),
        .pin_io_out (s_io_out),
        .pin_io_in  (s_io_in),
        .pin_io_oe  (s_oe),
        .ext_ready  (s_ready)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("phase", pin_phase, ex.ph);
            chk("strobe", pin_strobe, ex.stb);
            chk("busy", bus_busy, ex.busy);
            chk("ack", bus.cpu_ack, ex.ack);
            chk("err", bus.cpu_err, ex.err);
            chk("oe", pin_io_oe, ex.oe_on ? 8'hFF : 8'h00);
            chk("rdata", bus.cpu_rdata, ex.rdata);
            if (ex.chk_pa) chk("pin_addr", pin_addr, ex.pa);
            if (ex.chk_pio) chk("pin_io_out", pin_io_out, ex.pio);
            if (cyc < 64) obs_pa[cyc] = pin_addr;
            if (bus.cpu_ack === 1'b1 && ack_cyc < 0) begin
                ack_cyc   = cyc;
                ack_err   = bus.cpu_err;
                ack_rdata = bus.cpu_rdata;
            end
        end
    end

    task automatic step(input exp_t e, input logic rdy, input logic [7:0] pin);
        @(posedge clk);
        #1;
        cyc++;
        ext_ready = rdy;
        pin_io_in = pin;
        bus.cpu_addr  = $urandom;
        bus.cpu_wdata = $urandom;
        bus.cpu_we    = 1'($urandom_range(0, 1));
        if (e.ack) bus.cpu_req = 1'b0;
        ex = e;
    endtask

    // Builds the expected cycle trace of one transaction from the protocol rules.
    task automatic run_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int s0, input int s1,
                           input int s2, input int s3);
        int   st [4];
        int   ns;
        bit   abort;
        exp_t e;
        st = '{s0, s1, s2, s3};
        abort = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        ack_cyc = -1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        ext_ready = 1'($urandom);
        pin_io_in = 8'($urandom);
        e = '{default: '0};
        e.rdata = prev_rd;
        ex = e;
        chk_en = 1'b1;
        e.busy = 1'b1;
        e.stb = 1'b1;
        e.ph = 2'b01;
        e.chk_pa = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e.pa = a[8*k +: 8];
            step(e, 1'($urandom), 8'($urandom));
        end
        e.ph = 2'b10;
        e.pa = we ? 8'h03 : 8'h02;
        step(e, 1'($urandom), 8'($urandom));
        e.ph = 2'b11;
        e.chk_pa = 1'b0;
        e.oe_on = we;
        e.chk_pio = we;
        for (int k = 0; k < 4 && !abort; k++) begin
            e.pio = wd[8*k +: 8];
            ns = (st[k] < TO) ? st[k] : TO;
            for (int s = 0; s < ns; s++) step(e, 1'b0, 8'($urandom));
            if (st[k] >= TO) abort = 1'b1;
            else step(e, 1'b1, rd[8*k +: 8]);
        end
        if (!we && !abort) prev_rd = rd;
        e.ph = 2'b00;
        e.stb = 1'b0;
        e.oe_on = 1'b0;
        e.chk_pio = 1'b0;
        e.ack = 1'b1;
        e.err = abort;
        e.rdata = prev_rd;
        step(e, 1'($urandom), 8'($urandom));
        e.ack = 1'b0;
        e.err = 1'b0;
        e.busy = 1'b0;
        step(e, 1'($urandom), 8'($urandom));
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, "_phase"}, pin_phase, 2'b00);
        chk({n, "_strobe"}, pin_strobe, 1'b0);
        chk({n, "_busy"}, bus_busy, 1'b0);
        chk({n, "_oe"}, pin_io_oe, 8'h00);
        chk({n, "_io_out"}, pin_io_out, 8'h00);
        chk({n, "_addr"}, pin_addr, 8'h00);
        chk({n, "_ack"}, bus.cpu_ack, 1'b0);
        chk({n, "_err"}, bus.cpu_err, 1'b0);
        chk({n, "_rdata"}, bus.cpu_rdata, 32'h0);
    endtask

    task automatic reset_mid_write();
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'hDEADBEEF;
        bus.cpu_wdata = 32'h01020304;
        ext_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        cyc = 7;
        chk("rst5_pre_oe", pin_io_oe, 8'hFF);
        chk("rst5_pre_io", pin_io_out, 8'h03);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst5");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_rd = '0;
    endtask

    task automatic small_test();
        int         ph  [8] = '{1, 1, 1, 1, 2, 3, 3, 0};
        logic [3:0] pa  [5] = '{4'h3, 4'hC, 4'h5, 4'hA, 4'h3};
        logic [3:0] pio [2] = '{4'hE, 4'h7};
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        b4.cpu_req   = 1'b1;
        b4.cpu_we    = 1'b1;
        b4.cpu_addr  = 16'hA5C3;
        b4.cpu_wdata = 8'h7E;
        s_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            if (c == 1) b4.cpu_req = 1'b0;
            @(negedge clk);
            chk("s_phase", s_phase, ph[c-1]);
            chk("s_ack", b4.cpu_ack, c == 8);
            if (c <= 5) chk("s_pin_addr", s_addr, pa[c-1]);
            if (c == 6 || c == 7) begin
                chk("s_io_out", s_io_out, pio[c-6]);
                chk("s_oe", s_oe, 4'hF);
            end
        end
    endtask

    initial begin
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        ext_ready = 1'b0;
        pin_io_in = '0;
        b4.cpu_req = 1'b0;
        b4.cpu_we = 1'b0;
        b4.cpu_addr = '0;
        b4.cpu_wdata = '0;
        s_ready = 1'b0;
        s_io_in = '0;
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_txn(1'b1, 32'h12345678, 32'hCAFEBABE, 32'h0, 0, 0, 0, 0);
        chk("t1_ack_cyc", ack_cyc, 10);
        chk("t1_err", ack_err, 1'b0);
        chk("t1_pa_b0", obs_pa[1], 8'h78);
        chk("t1_pa_b3", obs_pa[4], 8'h12);
        chk("t1_cmd", obs_pa[5], 8'h03);

        run_txn(1'b0, 32'h00000010, 32'h0, 32'h44332211, 0, 0, 0, 0);
        chk("t2_cmd", obs_pa[5], 8'h02);
        chk("t2_rdata", ack_rdata, 32'h44332211);

        run_txn(1'b0, 32'h00000020, 32'h0, 32'hA1B2C3D4, 0, 0, 3, 0);
        chk("t3_ack_cyc", ack_cyc, 13);
        chk("t3_rdata", ack_rdata, 32'hA1B2C3D4);

        run_txn(1'b0, 32'h00000030, 32'h0, 32'h55667788, 100, 0, 0, 0);
        chk("t4_ack_cyc", ack_cyc, 21);
        chk("t4_err", ack_err, 1'b1);
        chk("t4_rdata", ack_rdata, 32'hA1B2C3D4);

        run_txn(1'b0, 32'h00000040, 32'h0, 32'h0BADF00D, 14, 0, 0, 0);
        chk("t4b_ack_cyc", ack_cyc, 24);
        chk("t4b_err", ack_err, 1'b0);

        reset_mid_write();
        run_txn(1'b1, 32'h89ABCDEF, 32'h13572468, 32'h0, 0, 1, 0, 2);
        chk("t5_ack_cyc", ack_cyc, 13);

        for (int t = 0; t < 40; t++) begin
            int st [4];
            for (int k = 0; k < 4; k++) begin
                st[k] = ($urandom_range(0, 7) == 0) ? 13 + int'($urandom_range(0, 3))
                                                   : int'($urandom_range(0, 2));
            end
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    st[0], st[1], st[2], st[3]);
        end

        small_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
